// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit lookahead group per stage,
// one result per clock, valid/ready on both sides with a single global stall.
module cla_pipe_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int unsigned NG = WIDTH / 4;

  if (WIDTH % 4 != 0 || WIDTH < 4) begin : g_bad_width
    $error("cla_pipe_addsub: WIDTH must be a multiple of 4 and at least 4");
  end

  // Returns {carry into bit 3, group carry-out, 4-bit group sum}.
  function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] p, g, c, s;
    logic       c4;
    p    = x ^ y;
    g    = x & y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
           (&p & ci);
    s    = p ^ c;
    return {c[3], c4, s};
  endfunction

  logic             w_en;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  assign w_en     = !out_valid | out_ready;
  assign in_ready = rst_n & w_en;
  assign w_b_eff  = b ^ {WIDTH{sub}};
  assign w_c0     = cin ^ sub;

  for (genvar k = 0; k < NG; k++) begin : g_stage
    // Remaining operand bits, current group in [3:0].
    logic [WIDTH-4*k-1:0] w_oa, w_ob;
    logic                 w_ci, w_vi;
    logic [5:0]           w_res;
    logic [4*k+3:0]       w_sum_n;
    logic [4*k+3:0]       r_sum;
    logic                 r_co;
    logic                 r_v;

    if (k == 0) begin : g_first
      assign w_oa    = a;
      assign w_ob    = w_b_eff;
      assign w_ci    = w_c0;
      assign w_vi    = in_valid;
      assign w_sum_n = w_res[3:0];
    end else begin : g_next
      assign w_oa    = g_stage[k-1].g_fwd.r_a;
      assign w_ob    = g_stage[k-1].g_fwd.r_b;
      assign w_ci    = g_stage[k-1].r_co;
      assign w_vi    = g_stage[k-1].r_v;
      assign w_sum_n = {w_res[3:0], g_stage[k-1].r_sum};
    end

    assign w_res = cla4(w_oa[3:0], w_ob[3:0], w_ci);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sum <= '0;
        r_co  <= 1'b0;
        r_v   <= 1'b0;
      end else if (w_en) begin
        r_sum <= w_sum_n;
        r_co  <= w_res[4];
        r_v   <= w_vi;
      end
    end

    if (k < NG - 1) begin : g_fwd
      logic [WIDTH-4*k-5:0] r_a, r_b;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_oa[WIDTH-4*k-1:4];
          r_b <= w_ob[WIDTH-4*k-1:4];
        end
      end
    end else begin : g_last
      // Zero is registered so it reads 0 after reset even though sum is 0.
      logic r_c3;
      logic r_zero;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_c3   <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_en) begin
          r_c3   <= w_res[5];
          r_zero <= (w_sum_n == '0);
        end
      end
    end
  end

  assign out_valid = g_stage[NG-1].r_v;
  assign sum       = g_stage[NG-1].r_sum;
  assign cout      = g_stage[NG-1].r_co;
  assign ovf       = g_stage[NG-1].r_co ^ g_stage[NG-1].g_last.r_c3;
  assign zero      = g_stage[NG-1].g_last.r_zero;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub at WIDTH 4/16/32 against an integer-arithmetic reference model.
module tb_cla_pipe_addsub;
  typedef logic [34:0] res_t;  // {ovf, cout, zero, sum zero-extended to 32}

  typedef struct packed {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, of, z;
  } dv_t;

  localparam dv_t DV [7] = '{
    '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0},
    '{16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 1'b0},
    '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0},
    '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1},
    '{16'h0003, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0}
  };

  logic        clk = 1'b0;
  logic        rst_n, cin, sub, out_ready, iv4, iv16, iv32;
  logic [31:0] a, b;
  logic        rdy4, ov4, co4, of4, z4;
  logic        rdy16, ov16, co16, of16, z16;
  logic        rdy32, ov32, co32, of32, z32;
  logic [3:0]  s4;
  logic [15:0] s16;
  logic [31:0] s32;
  int          n_vec = 0;
  int          n_err = 0;
  res_t        q4[$], q16[$], q32[$];

  always #5 clk = ~clk;

  cla_pipe_addsub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(rdy4), .a(a[3:0]), .b(b[3:0]),
    .cin(cin), .sub(sub), .out_valid(ov4), .out_ready(out_ready), .sum(s4), .cout(co4),
    .ovf(of4), .zero(z4));

  cla_pipe_addsub #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16), .a(a[15:0]), .b(b[15:0]),
    .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready), .sum(s16), .cout(co16),
    .ovf(of16), .zero(z16));

  cla_pipe_addsub #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32),
    .ovf(of32), .zero(z32));

  // Reference: plain integer add/subtract on w-bit operands.
  function automatic res_t model(int w, logic [31:0] xa, logic [31:0] xb, logic xc, logic xs);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'(xa) & m;
    longint ub   = longint'(xb) & m;
    longint sa   = (ua >= half) ? ua - (m + 1) : ua;
    longint sb   = (ub >= half) ? ub - (m + 1) : ub;
    longint r, sr;
    logic   co;
    if (!xs) begin
      r  = ua + ub + longint'(xc);
      co = (r > m);
      sr = sa + sb + longint'(xc);
    end else begin
      r  = ua - ub - longint'(xc);
      co = (ua >= ub + longint'(xc));
      sr = sa - sb - longint'(xc);
    end
    return {(sr >= half) || (sr < -half), co, (r & m) == 0, 32'(r & m)};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      q4.delete();
      q16.delete();
      q32.delete();
    end else begin
      if (iv4 && rdy4)   q4.push_back(model(4, a, b, cin, sub));
      if (iv16 && rdy16) q16.push_back(model(16, a, b, cin, sub));
      if (iv32 && rdy32) q32.push_back(model(32, a, b, cin, sub));
    end
  end

  function automatic res_t got(int w);
    case (w)
      4:       return {of4, co4, z4, 28'd0, s4};
      32:      return {of32, co32, z32, s32};
      default: return {of16, co16, z16, 16'd0, s16};
    endcase
  endfunction

  function automatic logic ovld(int w);
    case (w)
      4:       return ov4;
      32:      return ov32;
      default: return ov16;
    endcase
  endfunction

  function automatic int qsize(int w);
    case (w)
      4:       return q4.size();
      32:      return q32.size();
      default: return q16.size();
    endcase
  endfunction

  function automatic res_t qpop(int w);
    case (w)
      4:       return q4.pop_front();
      32:      return q32.pop_front();
      default: return q16.pop_front();
    endcase
  endfunction

  task automatic set_iv(int w, logic v);
    case (w)
      4:       iv4 = v;
      32:      iv32 = v;
      default: iv16 = v;
    endcase
  endtask

  task automatic test_reset();
    int ws[3] = '{4, 16, 32};
    rst_n = 1'b0; iv4 = 1'b0; iv16 = 1'b0; iv32 = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (rdy16 !== 1'b0) begin
      n_err++; $display("FAIL reset_in_ready got=%b exp=0", rdy16);
    end
    foreach (ws[i]) begin
      n_vec++;
      if ({ovld(ws[i]), got(ws[i])} !== 36'd0) begin
        n_err++;
        $display("FAIL reset_outputs w=%0d got=%h exp=0", ws[i], {ovld(ws[i]), got(ws[i])});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (rdy16 !== 1'b1) begin
      n_err++; $display("FAIL idle_in_ready got=%b exp=1", rdy16);
    end
  endtask

  task automatic test_directed();
    int   edges;
    res_t exp;
    foreach (DV[i]) begin
      @(negedge clk);
      a = {16'd0, DV[i].a}; b = {16'd0, DV[i].b}; cin = DV[i].cin; sub = DV[i].sub;
      out_ready = 1'b1; iv16 = 1'b1;
      @(negedge clk);
      iv16  = 1'b0;
      edges = 1;
      while (!ov16 && edges < 20) begin
        @(negedge clk);
        edges++;
      end
      n_vec++;
      if (edges !== 4) begin
        n_err++; $display("FAIL directed_latency vec=%0d got=%0d exp=4", i, edges);
      end
      exp = {DV[i].of, DV[i].co, DV[i].z, 16'd0, DV[i].s};
      n_vec++;
      if (got(16) !== exp) begin
        n_err++; $display("FAIL directed_result vec=%0d got=%h exp=%h", i, got(16), exp);
      end
      if (qsize(16) > 0) void'(qpop(16));
    end
  endtask

  task automatic test_stream(int w);
    int   ng    = w / 4;
    int   n_out = 0;
    int   first = -1;
    int   last  = -1;
    res_t exp;
    out_ready = 1'b1;
    for (int c = 0; c < 8 + ng + 4; c++) begin
      @(negedge clk);
      if (ovld(w)) begin
        n_vec++;
        if (qsize(w) == 0) begin
          n_err++; $display("FAIL stream_extra w=%0d cyc=%0d got=%h exp=none", w, c, got(w));
        end else begin
          exp = qpop(w);
          if (got(w) !== exp) begin
            n_err++; $display("FAIL stream_result w=%0d cyc=%0d got=%h exp=%h", w, c, got(w), exp);
          end
        end
        if (first < 0) first = c;
        last = c;
        n_out++;
      end
      if (c < 8) begin
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        set_iv(w, 1'b1);
      end else begin
        set_iv(w, 1'b0);
      end
    end
    n_vec++;
    if (n_out !== 8 || first !== ng || last !== ng + 7) begin
      n_err++;
      $display("FAIL stream_timing w=%0d got=%0d/%0d..%0d exp=8/%0d..%0d", w, n_out, first, last,
               ng, ng + 7);
    end
  endtask

  task automatic test_backpressure();
    int   n_in  = 0;
    int   n_out = 0;
    int   last  = -1;
    res_t snap  = '0;
    res_t exp;
    for (int c = 0; c < 30 && n_out < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 6 && c < 9);
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      iv16 = (n_in < 8);
      #1;
      if (c == 6) snap = got(16);
      if (c > 6 && c <= 9) begin
        n_vec++;
        if (got(16) !== snap) begin
          n_err++; $display("FAIL stall_hold cyc=%0d got=%h exp=%h", c, got(16), snap);
        end
      end
      if (c >= 6 && c < 9) begin
        n_vec++;
        if (rdy16 !== 1'b0) begin
          n_err++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, rdy16);
        end
      end
      if (c >= 4) begin
        n_vec++;
        if (ov16 !== 1'b1) begin
          n_err++; $display("FAIL stall_gap cyc=%0d got=%b exp=1", c, ov16);
        end
      end
      if (rdy16 && iv16) n_in++;
      if (ov16 && out_ready) begin
        n_vec++;
        if (qsize(16) == 0) begin
          n_err++; $display("FAIL stall_extra cyc=%0d got=%h exp=none", c, got(16));
        end else begin
          exp = qpop(16);
          if (got(16) !== exp) begin
            n_err++; $display("FAIL stall_result cyc=%0d got=%h exp=%h", c, got(16), exp);
          end
        end
        n_out++;
        last = c;
      end
    end
    iv16 = 1'b0;
    out_ready = 1'b1;
    n_vec++;
    if (n_out !== 8 || last !== 14) begin
      n_err++; $display("FAIL stall_drain got=%0d@%0d exp=8@14", n_out, last);
    end
  endtask

  task automatic test_reset_mid();
    int   edges;
    res_t exp;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      iv16 = 1'b1;
    end
    @(negedge clk);
    iv16 = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    #1;
    n_vec++;
    if (rdy16 !== 1'b0) begin
      n_err++; $display("FAIL midreset_in_ready got=%b exp=0", rdy16);
    end
    @(negedge clk);
    n_vec++;
    if ({ov16, got(16)} !== 36'd0) begin
      n_err++; $display("FAIL midreset_outputs got=%h exp=0", {ov16, got(16)});
    end
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_vec++;
      if (ov16 !== 1'b0) begin
        n_err++; $display("FAIL midreset_stale cyc=%0d got=%b exp=0", c, ov16);
      end
    end
    a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    exp  = model(16, a, b, cin, sub);
    iv16 = 1'b1;
    @(negedge clk);
    iv16  = 1'b0;
    edges = 1;
    while (!ov16 && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    n_vec++;
    if (edges !== 4 || got(16) !== exp) begin
      n_err++;
      $display("FAIL midreset_first got=%h@%0d exp=%h@4", got(16), edges, exp);
    end
    if (qsize(16) > 0) void'(qpop(16));
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stream(16);
    test_stream(4);
    test_stream(32);
    test_backpressure();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/cla_pipe_addsub.md
# cla_pipe_addsub

Parametrised, pipelined carry-lookahead adder/subtractor. Each pipeline stage resolves one 4-bit lookahead group (generate/propagate, group carry, group sum) and passes the group carry-out to the next stage, giving one result per clock at any WIDTH. It sits between operand-producing logic and a result consumer, with valid/ready handshakes on both sides. It also reports carry/borrow, signed overflow and zero flags.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4; violation is an elaboration error
- NG (localparam), WIDTH/4, number of groups, which equals the number of pipeline stages
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operand set a/b/cin/sub is valid
- in_ready  output  1  block accepts the operand set this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; acts as borrow-in when sub=1
- sub  input  1  0 selects a+b+cin; 1 selects a−b−cin
- out_valid  output  1  result outputs are valid
- out_ready  input  1  consumer takes the result this cycle
- sum  output  WIDTH  result
- cout  output  1  carry out of bit WIDTH−1 (for sub: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow
- zero  output  1  sum == 0

## Operation
- Subtract mode: the effective B input is b ^ {WIDTH{sub}}, and the effective carry-in is cin ^ sub.
  - sub=1, cin=0 gives a−b.
  - sub=1, cin=1 gives a−b−1.
- Group k covers bits [4k+3:4k]:
  - p = a ^ b_eff and g = a & b_eff per bit.
  - Carries inside the group use the lookahead form c(i+1) = g(i) | p(i)&c(i), all derived from the group carry-in.
  - s(i) = p(i) ^ c(i).
- Stage k computes group k and registers:
  - the partial sum bits [4k+3:0];
  - the group carry-out;
  - the still-unprocessed upper operand bits (p, g, or a/b_eff);
  - a stage valid bit;
  - the carry into bit 4k+3 (the MSB of group k), kept only at the last stage.
- Final stage (NG−1) register drives the outputs:
  - sum = assembled result;
  - cout = c(WIDTH);
  - ovf = c(WIDTH) ^ c(WIDTH−1);
  - zero = (sum == 0).
- Global stall: en = !out_valid | out_ready.
  - All stage registers, including valid bits, advance only when en=1.
  - in_ready = en while rst_n=1; in_ready = 0 while rst_n=0.
  - Accept occurs when in_valid & in_ready at a rising edge.
  - Bubbles are not compressed. An empty stage still advances only with en.
- Results emerge in acceptance order. No reordering, no drops, no duplication.
- When stalled (out_valid=1, out_ready=0), sum/cout/ovf/zero/out_valid are held stable.
- Operands presented while in_ready=0 are ignored.

## Timing
- Reset (rst_n=0 at a rising edge):
  - All stage valid bits clear; out_valid=0.
  - sum=0, cout=0, ovf=0, zero=0 from the following cycle.
  - Every in-flight transaction is discarded and never appears at the outputs.
- Reset mid-stall behaves the same. out_ready is ignored during reset.
- Latency is NG edges. For an operand accepted at edge t with no stall, out_valid=1 and the result are visible after edge t+NG−1.
  - WIDTH=4: visible the cycle after accept.
  - WIDTH=16: after the 4th edge counting the accept edge.
- Throughput is one result per cycle when in_valid=1 and out_ready=1 continuously.
- A stall of N cycles delays every in-flight result by exactly N cycles.
- Simultaneous accept and output drain in the same cycle are allowed; this is normal streaming.
- out_ready is sampled only when out_valid=1. A result completes on an edge where out_valid & out_ready.
- No combinational path exists from a/b/cin/sub to any output. in_ready depends combinationally on out_ready.

## Test plan
- **Wrap-around carry:** WIDTH=16, add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, zero=1, ovf=0, out_valid after 4th edge from accept.
- **Signed overflow and carry chain:**
  - add 0x7FFF + 0x0001 -> sum=0x8000, ovf=1, cout=0.
  - add 0x00FF + 0x0F01, cin=1 -> sum=0x1001, cout=0, ovf=0 (carry crosses group boundaries).
- **Subtract:**
  - 0x0005 − 0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - 0x8000 − 0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - 0x0003 − 0x0003 -> zero=1, cout=1.
  - 0x0003 − 0x0001 with cin=1 -> sum=0x0001.
- **Streaming:** 8 back-to-back random transactions, out_ready=1 -> 8 results on 8 consecutive cycles, in order, each matching a reference model. Repeat at WIDTH=4 and WIDTH=32.
- **Backpressure:** out_ready=0 for 3 cycles while out_valid=1 -> outputs held bit-stable, in_ready=0, no accepts. On release, every result appears exactly once, in order, with no gaps beyond pipeline bubbles.
- **Reset mid-stream:** 3 transactions in flight, rst_n=0 for one edge -> next cycle out_valid=0, sum=0, flags=0, in_ready=0 during reset. After release, no pre-reset result appears, and the first new accept returns after NG edges.
